// File: rtl/dm_arbiter_if.sv
// Request/response and data-memory signals of the two-port data-memory arbiter.
// slave = arbiter side, master = requesters plus the dataMemory model.
interface dm_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [63:0] addr0;
   logic [63:0] addr1;
   logic [63:0] wdata0;
   logic [63:0] wdata1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [63:0] rdata0;
   logic [63:0] rdata1;
   logic [63:0] mem_address;
   logic [63:0] mem_writeData;
   logic        mem_memRead;
   logic        mem_memWrite;
   logic [63:0] mem_readData;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readData,
      output ack0, ack1, err0, err1, rdata0, rdata1,
             mem_address, mem_writeData, mem_memRead, mem_memWrite
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readData,
      input  ack0, ack1, err0, err1, rdata0, rdata1,
             mem_address, mem_writeData, mem_memRead, mem_memWrite
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port 64-bit dataMemory.
// Optional macro DM_ARB_FIXED_PRIO_EN: port 0 always wins, no round-robin pointer.
//
// state | meaning
// IDLE  | wait for a request, grant a port, latch it, check the address
// ISSUE | drive strobe and address/data to memory
// WAIT  | hold memRead until READ_LATENCY has elapsed
// ERR   | bad address, no memory access, respond with err
// RESP  | one-cycle ack (and err) to the granted port
module dm_arbiter #(
   parameter int MEM_BYTES    = 8192,
   parameter int READ_LATENCY = 0
) (
   input  logic         clock,
   input  logic         reset,
   dm_arbiter_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ERR, RESP} state_t;

   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd8;
   localparam logic [1:0]  LAT_LOAD  = 2'(READ_LATENCY);

   state_t      stateQ, stateD;
   logic        grantQ, grantD;
   logic        weQ, weD;
   logic [1:0]  cntQ, cntD;
   logic [63:0] addrQ, addrD;
   logic [63:0] wdataQ, wdataD;
   logic        memReadQ, memReadD;
   logic        memWriteQ, memWriteD;
   logic        ack0Q, ack0D, ack1Q, ack1D;
   logic        err0Q, err0D, err1Q, err1D;
   logic [63:0] rdata0Q, rdata0D, rdata1Q, rdata1D;
   logic        captureRd;

   logic        grantSel;
   logic        anyReq;
   logic        selWe;
   logic [63:0] selAddr;
   logic [63:0] selWdata;
   logic        addrErr;

   assign anyReq = bus.req0 || bus.req1;

`ifdef DM_ARB_FIXED_PRIO_EN
   assign grantSel = !bus.req0;
`else
   logic rrQ;

   // rrQ = port favoured on a tie; flips to the other port after every grant
   assign grantSel = (bus.req0 && bus.req1) ? rrQ : !bus.req0;

   always_ff @(posedge clock) begin
      if (reset) begin
         rrQ <= 1'b0;
      end else if (stateQ == IDLE && anyReq) begin
         rrQ <= !grantSel;
      end
   end
`endif

   assign selWe    = grantSel ? bus.we1    : bus.we0;
   assign selAddr  = grantSel ? bus.addr1  : bus.addr0;
   assign selWdata = grantSel ? bus.wdata1 : bus.wdata0;

   // full 64-bit unsigned compare so huge addresses cannot wrap into range
   assign addrErr = (selAddr[2:0] != 3'b000) || (selAddr > LAST_ADDR);

   always_comb begin
      stateD    = stateQ;
      grantD    = grantQ;
      weD       = weQ;
      cntD      = cntQ;
      addrD     = addrQ;
      wdataD    = wdataQ;
      memReadD  = 1'b0;
      memWriteD = 1'b0;
      captureRd = 1'b0;

      case (stateQ)
         IDLE: begin
            if (anyReq) begin
               grantD = grantSel;
               weD    = selWe;
               if (addrErr) begin
                  stateD = ERR;
               end else begin
                  stateD    = ISSUE;
                  addrD     = selAddr;
                  wdataD    = selWdata;
                  memReadD  = !selWe;
                  memWriteD = selWe;
               end
            end
         end
         ISSUE: begin
            if (weQ || READ_LATENCY == 0) begin
               stateD    = RESP;
               captureRd = !weQ;
            end else begin
               stateD   = WAIT;
               cntD     = LAT_LOAD;
               memReadD = 1'b1;
            end
         end
         WAIT: begin
            if (cntQ == 2'd1) begin
               stateD    = RESP;
               captureRd = 1'b1;
            end else begin
               cntD     = cntQ - 2'd1;
               memReadD = 1'b1;
            end
         end
         ERR: begin
            stateD = RESP;
         end
         RESP: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // outputs are registered so they line up with the state they belong to
   always_comb begin
      ack0D   = (stateD == RESP) && !grantQ;
      ack1D   = (stateD == RESP) &&  grantQ;
      err0D   = (stateQ == ERR)  && !grantQ;
      err1D   = (stateQ == ERR)  &&  grantQ;
      rdata0D = (captureRd && !grantQ) ? bus.mem_readData : rdata0Q;
      rdata1D = (captureRd &&  grantQ) ? bus.mem_readData : rdata1Q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ    <= IDLE;
         grantQ    <= 1'b0;
         weQ       <= 1'b0;
         cntQ      <= 2'd0;
         addrQ     <= 64'd0;
         wdataQ    <= 64'd0;
         memReadQ  <= 1'b0;
         memWriteQ <= 1'b0;
         ack0Q     <= 1'b0;
         ack1Q     <= 1'b0;
         err0Q     <= 1'b0;
         err1Q     <= 1'b0;
         rdata0Q   <= 64'd0;
         rdata1Q   <= 64'd0;
      end else begin
         stateQ    <= stateD;
         grantQ    <= grantD;
         weQ       <= weD;
         cntQ      <= cntD;
         addrQ     <= addrD;
         wdataQ    <= wdataD;
         memReadQ  <= memReadD;
         memWriteQ <= memWriteD;
         ack0Q     <= ack0D;
         ack1Q     <= ack1D;
         err0Q     <= err0D;
         err1Q     <= err1D;
         rdata0Q   <= rdata0D;
         rdata1Q   <= rdata1D;
      end
   end

   assign bus.ack0          = ack0Q;
   assign bus.ack1          = ack1Q;
   assign bus.err0          = err0Q;
   assign bus.err1          = err1Q;
   assign bus.rdata0        = rdata0Q;
   assign bus.rdata1        = rdata1Q;
   assign bus.mem_address   = addrQ;
   assign bus.mem_writeData = wdataQ;
   assign bus.mem_memRead   = memReadQ;
   assign bus.mem_memWrite  = memWriteQ;
endmodule
